ocra1_word_sched: RTL and testbench
===================================

Name: ocra1_word_sched

Overview:
- Upstream feeder for the OCRA1 four-channel SPI serialiser.
- Accepts 32-bit gradient words from the gradient BRAM reader and buffers them in a small FIFO.
- Issues single-cycle valid pulses to the serialiser. Channel-load words go out promptly; broadcast words are paced by a programmable update interval and by the serialiser's busy flag.
- Flags sticky lateness when a broadcast misses its slot.

Parameters:
- FIFO_DEPTH, 16: buffer entries; power of 2, range 4..256.
- GUARD_CYCLES, 3: cycles after a broadcast issue before busy_i is trusted. Covers the serialiser's 2-cycle valid-to-busy latency plus 1 margin.

Ports:
- clk  in  1  system clock (122.88 MHz)
- rst_n  in  1  asynchronous active-low reset
- enable_i  in  1  run enable; low = no new pops
- flush_i  in  1  empty FIFO; honoured only while enable_i=0
- interval_i  in  16  minimum cycles between broadcast issues; 0 treated as 1
- word_i  in  32  bits 26:25 channel, bit 24 broadcast, 23:0 payload
- word_valid_i  in  1  upstream word present
- word_ready_o  out  1  = FIFO not full; handshake on valid&ready
- data_o  out  32  word to serialiser data_i
- valid_o  out  1  1-cycle pulse to serialiser valid_i
- busy_i  in  1  from serialiser busy_o
- late_o  out  1  sticky lateness flag
- clear_late_i  in  1  clears late_o
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset values (async, rst_n=0): data_o=0, valid_o=0, late_o=0, FIFO empty, fifo_level_o=0, interval timer=0 (expired), state IDLE, armed=0. word_ready_o=1 once reset is released.
- FIFO: registered write. A pushed word is first poppable the cycle after the push. When full, word_ready_o=0 and the push is ignored. Simultaneous push and pop when non-empty: level unchanged. Pointers wrap modulo FIFO_DEPTH.
- Timer: 16-bit down-counter. Loaded with max(interval_i,1)-1 on each broadcast issue. Decrements to 0 and holds; expired = (timer==0).
- States:
  - IDLE: requires enable_i=1 and FIFO non-empty.
    - Head bit24=0: pop; next cycle data_o=head, valid_o=1; go GAP.
    - Head bit24=1 with expired && !busy_i: pop, issue likewise, reload timer, armed=1, load guard counter with GUARD_CYCLES; go GUARD.
    - Otherwise stay.
  - GAP: 1 cycle, then IDLE. Guarantees at least 1 idle cycle between valid pulses, so the serialiser's 2-stage capture pipeline never overlaps.
  - GUARD: decrement; at 0 go IDLE. busy_i is ignored here.
- Issue latency: pop decision to valid_o is 1 cycle. data_o holds its last value between pulses.
- Lateness: late_o sets when armed=1 && enable_i=1 && expired && state==IDLE && no broadcast issues that cycle. Causes: empty FIFO, channel words still pending, or busy_i high.
  - clear_late_i has priority over set in the same cycle.
  - armed clears when enable_i=0.
- Enable drop mid-operation: the current GAP/GUARD completes, no further pops occur, FIFO contents are retained.
- Flush: if flush_i=1 while enable_i=0, FIFO empties next cycle. Same-cycle push is discarded.
- Reset mid-operation: all state returns to reset values immediately. A pending valid_o pulse is cancelled.

Optional Feature:
- Macro: OCRA1_WORD_SCHED_STATS_EN.
- Defined: adds ports bcast_count_o (32 bit) and late_cycles_o (32 bit).
  - bcast_count_o increments on each broadcast issue.
  - late_cycles_o increments each cycle the late-set condition is true.
  - Both counters saturate at all-ones and clear on clear_late_i and on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package ocra1_pkg:
  - Word field constants: CH_MSB=26, CH_LSB=25, BCAST_BIT=24, PAYLOAD_W=24.
  - Default GUARD_CYCLES.
  - State encoding localparams IDLE/GAP/GUARD.
- Sub-module ocra1_word_fifo: synchronous FIFO with push/pop/flush and level output, reusable by other OCRA1 feeders.

Test Plan:
- Reset, then push 4 channel words (bit24=0, ch 0..3) with enable_i=1: 4 valid_o pulses spaced exactly 2 cycles; data_o matches in order; late_o=0.
- interval_i=100, push ch0 word then broadcast repeatedly with busy_i tied low: consecutive broadcast valid_o pulses exactly 100 cycles apart; level returns to 0.
- Hold busy_i=1 for 50 cycles after timer expiry while armed with a broadcast at head: no issue until busy_i falls; late_o=1; clear_late_i clears it.
- Busy_i asserted only 2 cycles after a broadcast issue: no extra pulse or stall error inside GUARD; next broadcast waits for busy_i=0.
- FIFO_DEPTH=16, push 20 words with enable_i=0: word_ready_o falls after 16 accepted; fifo_level_o=16. Flush → level 0, word_ready_o=1.
- Assert rst_n=0 for 1 cycle mid-GUARD with 5 words queued: valid_o=0, fifo_level_o=0, late_o=0 immediately; no pulses until new words are pushed.

Source files
------------

// File: rtl/ocra1_word_sched_pkg.sv
// ocra1_pkg: shared constants for the OCRA1 gradient word feeders.
// Holds the word field layout, the default broadcast guard length and the
// scheduler state encoding.
package ocra1_pkg;

    // Gradient word layout: [26:25] channel, [24] broadcast, [23:0] payload
    localparam int CH_MSB    = 26;
    localparam int CH_LSB    = 25;
    localparam int BCAST_BIT = 24;
    localparam int PAYLOAD_W = 24;

    // Serialiser valid-to-busy latency is 2 cycles; one extra cycle of margin
    localparam int GUARD_CYCLES_DEF = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GAP   = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        GAP   = ST_GAP,
        GUARD = ST_GUARD
    } state_t;

    // Timer reload for a programmed interval; an interval of 0 behaves as 1
    function automatic logic [15:0] interval_reload(input logic [15:0] iv);
        return (iv == 16'd0) ? 16'd0 : iv - 16'd1;
    endfunction

endpackage

// File: rtl/ocra1_word_sched_if.sv
// ocra1_word_sched_if: upstream word handshake plus serialiser-side
// valid/data/busy. The scheduler takes the slave view, the driver of words
// and the serialiser model take the master view.
interface ocra1_word_sched_if;
    logic [31:0] word_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        busy_i;

    modport slave  (input  word_i, word_valid_i, busy_i,
                    output word_ready_o, data_o, valid_o);
    modport master (output word_i, word_valid_i, busy_i,
                    input  word_ready_o, data_o, valid_o);
endinterface

// File: rtl/ocra1_word_sched_fifo.sv
// ocra1_word_fifo: synchronous FIFO with registered write, show-ahead read,
// flush and an occupancy output. DEPTH must be a power of 2 so the pointers
// wrap naturally. Flush wins over a same-cycle push or pop.
module ocra1_word_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [W-1:0]             o_rdata,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push & ~o_full  & ~i_flush;
    assign w_pop   = i_pop  & ~o_empty & ~i_flush;
    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rptr];

    // Storage write; contents need no reset, occupancy guards every read
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/ocra1_word_sched.sv
// ocra1_word_sched: feeder between the gradient BRAM reader and the OCRA1
// four-channel SPI serialiser. Channel-load words issue as soon as the
// scheduler is idle; broadcast words wait for the update interval timer and
// for the serialiser to be free. A broadcast slot missed while armed sets
// the sticky late flag.
// Optional build macro: OCRA1_WORD_SCHED_STATS_EN adds broadcast and
// late-cycle counters. GUARD_CYCLES must be at least 1.
module ocra1_word_sched
    import ocra1_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int GUARD_CYCLES = GUARD_CYCLES_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable_i,
    input  logic                          flush_i,
    input  logic [15:0]                   interval_i,
    input  logic                          clear_late_i,
    output logic                          late_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    ocra1_word_sched_if.slave             bus
`ifdef OCRA1_WORD_SCHED_STATS_EN
    ,
    output logic [31:0]                   bcast_count_o,
    output logic [31:0]                   late_cycles_o
`endif
);
    localparam int GW = $clog2(GUARD_CYCLES + 1);

    logic [31:0]   w_head;
    logic          w_empty;
    logic          w_full;
    logic          w_flush;
    logic          w_can_pop;
    logic          w_issue_ch;
    logic          w_issue_bc;
    logic          w_pop;
    logic          w_expired;
    logic          w_late_set;

    state_t        r_state;
    logic [15:0]   r_timer;
    logic [GW-1:0] r_guard;
    logic          r_armed;
    logic          r_late;
    logic          r_valid;
    logic [31:0]   r_data;

    // Flush only takes effect while the scheduler is stopped
    assign w_flush = flush_i & ~enable_i;

    ocra1_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bus.word_valid_i),
        .i_wdata (bus.word_i),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (fifo_level_o)
    );

    assign w_expired  = (r_timer == 16'd0);
    assign w_can_pop  = enable_i & ~w_empty & (r_state == IDLE);
    assign w_issue_ch = w_can_pop & ~w_head[BCAST_BIT];
    assign w_issue_bc = w_can_pop &  w_head[BCAST_BIT] & w_expired & ~bus.busy_i;
    assign w_pop      = w_issue_ch | w_issue_bc;
    // Armed and the slot is open, yet no broadcast leaves this cycle
    assign w_late_set = r_armed & enable_i & w_expired & (r_state == IDLE) & ~w_issue_bc;

    assign bus.word_ready_o = ~w_full;
    assign bus.data_o       = r_data;
    assign bus.valid_o      = r_valid;
    assign late_o           = r_late;

    // Issue FSM: one-cycle valid pulse, then GAP (channel) or GUARD (broadcast)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_guard <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_data  <= w_head;
                        r_valid <= 1'b1;
                        if (w_issue_bc) begin
                            r_guard <= GW'(GUARD_CYCLES);
                            r_state <= GUARD;
                        end else begin
                            r_state <= GAP;
                        end
                    end
                end
                GAP: r_state <= IDLE;
                GUARD: begin
                    // busy_i is not yet meaningful for the word just sent
                    if (r_guard <= GW'(1)) begin
                        r_guard <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_guard <= r_guard - GW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Update interval timer: reload on broadcast issue, count down to 0 and hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= 16'd0;
        end else if (w_issue_bc) begin
            r_timer <= interval_reload(interval_i);
        end else if (!w_expired) begin
            r_timer <= r_timer - 16'd1;
        end
    end

    // Lateness tracking: armed by a broadcast, disarmed by stopping; clear beats set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
            r_late  <= 1'b0;
        end else begin
            if (!enable_i)       r_armed <= 1'b0;
            else if (w_issue_bc) r_armed <= 1'b1;

            if (clear_late_i)    r_late <= 1'b0;
            else if (w_late_set) r_late <= 1'b1;
        end
    end

`ifdef OCRA1_WORD_SCHED_STATS_EN
    logic [31:0] r_bcast_cnt;
    logic [31:0] r_late_cnt;

    // Saturating statistics, cleared together with the late flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcast_cnt <= '0;
            r_late_cnt  <= '0;
        end else if (clear_late_i) begin
            r_bcast_cnt <= '0;
            r_late_cnt  <= '0;
        end else begin
            if (w_issue_bc && (r_bcast_cnt != '1)) r_bcast_cnt <= r_bcast_cnt + 32'd1;
            if (w_late_set && (r_late_cnt  != '1)) r_late_cnt  <= r_late_cnt  + 32'd1;
        end
    end

    assign bcast_count_o = r_bcast_cnt;
    assign late_cycles_o = r_late_cnt;
`endif

endmodule

// File: tb/tb_ocra1_word_sched.sv
// Testbench for ocra1_word_sched: FIFO fill/flush table, hand-written
// sequences for pacing, busy hold, guard and reset, and randomized streams
// checked against an event-level schedule model.
module tb_ocra1_word_sched;
    import ocra1_pkg::*;

    localparam int DEPTH = 16;
    localparam int G     = 3;
    localparam int RLEN  = 500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        clear_late_i = 1'b0;
    logic [15:0] interval_i = 16'd0;
    logic        late_o;
    logic [4:0]  fifo_level_o;
`ifdef OCRA1_WORD_SCHED_STATS_EN
    logic [31:0] bcast_count_o;
    logic [31:0] late_cycles_o;
`endif

    ocra1_word_sched_if bus ();

    always #4 clk = ~clk;

    ocra1_word_sched #(.FIFO_DEPTH(DEPTH), .GUARD_CYCLES(G)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .flush_i      (flush_i),
        .interval_i   (interval_i),
        .clear_late_i (clear_late_i),
        .late_o       (late_o),
        .fifo_level_o (fifo_level_o),
        .bus          (bus)
`ifdef OCRA1_WORD_SCHED_STATS_EN
        ,
        .bcast_count_o(bcast_count_o),
        .late_cycles_o(late_cycles_o)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          q_t[$];
    logic [31:0] q_d[$];

    typedef struct {
        int n;
        bit flush;
        bit pof;
        int exp_level;
        bit exp_ready;
    } fvec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; valid pulses are logged with the cycle count they appear in
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (bus.valid_o === 1'b1) begin
            q_t.push_back(cyc);
            q_d.push_back(bus.data_o);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [31:0] w);
        bus.word_valid_i = 1'b1;
        bus.word_i       = w;
        step();
        bus.word_valid_i = 1'b0;
    endtask

    function automatic logic [31:0] mkw(input bit bc, input logic [1:0] ch, input logic [23:0] p);
        return {5'd0, ch, bc, p};
    endfunction

    task automatic do_reset();
        enable_i = 1'b0; flush_i = 1'b0; clear_late_i = 1'b0;
        bus.word_valid_i = 1'b0; bus.busy_i = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        q_t.delete(); q_d.delete();
    endtask

    initial begin
        fvec_t       fv[6];
        int          bct[$];
        logic [31:0] wl[12];
        bit          busy_a[RLEN];
        int          et[$];
        int          c0, n, iv, ieff, t, s, lastbc, nbc, m;

        bus.word_i = '0; bus.word_valid_i = 1'b0; bus.busy_i = 1'b0;

        // ---- reset values ----
        rst_n = 1'b0;
        step();
        chk("reset data_o", bus.data_o, 0);
        chk("reset valid_o", bus.valid_o, 0);
        chk("reset late_o", late_o, 0);
        chk("reset level", fifo_level_o, 0);
        rst_n = 1'b1;
        step();
        chk("reset ready", bus.word_ready_o, 1);

        // ---- FIFO fill / flush table (enable_i=0 throughout) ----
        fv[0] = '{n: 3,  flush: 0, pof: 0, exp_level: 3,  exp_ready: 1};
        fv[1] = '{n: 15, flush: 0, pof: 0, exp_level: 15, exp_ready: 1};
        fv[2] = '{n: 16, flush: 0, pof: 0, exp_level: 16, exp_ready: 0};
        fv[3] = '{n: 20, flush: 0, pof: 0, exp_level: 16, exp_ready: 0};
        fv[4] = '{n: 20, flush: 1, pof: 0, exp_level: 0,  exp_ready: 1};
        fv[5] = '{n: 5,  flush: 1, pof: 1, exp_level: 0,  exp_ready: 1};
        for (int v = 0; v < 6; v++) begin
            flush_i = 1'b1; step(); flush_i = 1'b0;
            for (int i = 0; i < fv[v].n; i++) push(mkw(1'b0, 2'(i), 24'(i)));
            if (fv[v].flush) begin
                flush_i = 1'b1;
                bus.word_valid_i = fv[v].pof;
                step();
                flush_i = 1'b0;
                bus.word_valid_i = 1'b0;
            end
            chk($sformatf("fifo vec%0d level", v), fifo_level_o, fv[v].exp_level);
            chk($sformatf("fifo vec%0d ready", v), bus.word_ready_o, fv[v].exp_ready);
        end
        chk("no pulses while disabled", q_t.size(), 0);

        // ---- four channel words, pulses two cycles apart ----
        do_reset();
        enable_i = 1'b1;
        for (int i = 0; i < 4; i++) push(mkw(1'b0, 2'(i), 24'h100 + 24'(i)));
        steps(8);
        chk("ch4 pulse count", q_t.size(), 4);
        if (q_t.size() == 4) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("ch4 data%0d", i), q_d[i], mkw(1'b0, 2'(i), 24'h100 + 24'(i)));
            for (int i = 1; i < 4; i++)
                chk($sformatf("ch4 spacing%0d", i), q_t[i] - q_t[i-1], 2);
        end
        chk("ch4 late", late_o, 0);

        // ---- broadcast pacing at interval 100 ----
        do_reset();
        interval_i = 16'd100;
        enable_i = 1'b1;
        push(mkw(1'b0, 2'd0, 24'hABC));
        for (int i = 0; i < 3; i++) push(mkw(1'b1, 2'(i), 24'h200 + 24'(i)));
        steps(260);
        bct.delete();
        for (int i = 0; i < q_t.size(); i++) if (q_d[i][BCAST_BIT]) bct.push_back(q_t[i]);
        chk("pace bcast count", bct.size(), 3);
        if (bct.size() == 3) begin
            chk("pace gap1", bct[1] - bct[0], 100);
            chk("pace gap2", bct[2] - bct[1], 100);
        end
        chk("pace level", fifo_level_o, 0);

        // ---- busy held after expiry while armed ----
        do_reset();
        interval_i = 16'd10;
        enable_i = 1'b1;
        push(mkw(1'b1, 2'd1, 24'h300));
        steps(20);
        chk("armed empty late", late_o, 1);
        clear_late_i = 1'b1; step(); clear_late_i = 1'b0;
        bus.busy_i = 1'b1;
        push(mkw(1'b1, 2'd2, 24'h301));
        steps(49);
        chk("busy hold pulses", q_t.size(), 1);
        chk("busy hold late", late_o, 1);
        bus.busy_i = 1'b0;
        c0 = cyc;
        steps(2);
        chk("busy release pulses", q_t.size(), 2);
        if (q_t.size() == 2) begin
            chk("busy release data", q_d[1], mkw(1'b1, 2'd2, 24'h301));
            chk("busy release time", q_t[1], c0 + 1);
        end
        clear_late_i = 1'b1; step(); clear_late_i = 1'b0;
        chk("clear late", late_o, 0);

        // ---- busy rises inside GUARD ----
        do_reset();
        interval_i = 16'd1;
        enable_i = 1'b1;
        push(mkw(1'b1, 2'd0, 24'h400));
        push(mkw(1'b1, 2'd1, 24'h401));
        chk("guard first pulse", q_t.size(), 1);
        step();
        bus.busy_i = 1'b1;
        steps(10);
        chk("guard no extra pulse", q_t.size(), 1);
        bus.busy_i = 1'b0;
        c0 = cyc;
        steps(3);
        chk("guard second pulse", q_t.size(), 2);
        if (q_t.size() == 2) begin
            chk("guard second data", q_d[1], mkw(1'b1, 2'd1, 24'h401));
            chk("guard second time", q_t[1], c0 + 1);
        end

        // ---- reset in the middle of GUARD ----
        do_reset();
        interval_i = 16'd1000;
        for (int i = 0; i < 6; i++) push(mkw(1'b1, 2'(i), 24'h500 + 24'(i)));
        enable_i = 1'b1;
        step();
        chk("midrst pulse seen", q_t.size(), 1);
        chk("midrst level before", fifo_level_o, 5);
        rst_n = 1'b0;
        #1;
        chk("midrst valid", bus.valid_o, 0);
        chk("midrst level", fifo_level_o, 0);
        chk("midrst late", late_o, 0);
        step();
        rst_n = 1'b1;
        steps(10);
        chk("midrst silent", q_t.size(), 1);
        push(mkw(1'b0, 2'd3, 24'h5FF));
        steps(3);
        chk("midrst new word", q_t.size(), 2);

        // ---- randomized streams vs event-level schedule model ----
        for (int r = 0; r < 4; r++) begin
            do_reset();
            iv = $urandom_range(0, 20);
            ieff = (iv == 0) ? 1 : iv;
            interval_i = 16'(iv);
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                wl[i] = mkw(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 24'($urandom));
                push(wl[i]);
            end
            for (int k = 0; k < RLEN; k++) busy_a[k] = ($urandom_range(0, 3) == 0);
            // Channel word: issue when idle, idle again 2 cycles later.
            // Broadcast: not before previous broadcast + interval, only on a
            // non-busy cycle, idle again after the pulse plus the guard.
            et.delete();
            t = 0; lastbc = -100000; nbc = 0;
            for (int i = 0; i < n; i++) begin
                if (!wl[i][BCAST_BIT]) begin
                    et.push_back(t);
                    t = t + 2;
                end else begin
                    s = (t > lastbc + ieff) ? t : lastbc + ieff;
                    while (s < RLEN && busy_a[s]) s++;
                    et.push_back(s);
                    lastbc = s;
                    t = s + 1 + G;
                    nbc++;
                end
            end
            c0 = cyc;
            enable_i = 1'b1;
            for (int k = 0; k < RLEN; k++) begin
                bus.busy_i = busy_a[k];
                step();
            end
            chk($sformatf("rnd%0d pulse count", r), q_t.size(), n);
            m = (q_t.size() < n) ? q_t.size() : n;
            for (int i = 0; i < m; i++) begin
                chk($sformatf("rnd%0d time%0d", r, i), q_t[i] - c0 - 1, et[i]);
                chk($sformatf("rnd%0d data%0d", r, i), q_d[i], wl[i]);
            end
            chk($sformatf("rnd%0d late", r), late_o, (nbc > 0) ? 1 : 0);
            chk($sformatf("rnd%0d level", r), fifo_level_o, 0);
            enable_i = 1'b0;
            bus.busy_i = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
